// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and sizing helper for alu_nbit_seq.
package alu_pkg;

  localparam logic [3:0] OP_NOTA = 4'b0000;
  localparam logic [3:0] OP_NOTB = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } alu_state_e;

  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(x)) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_n.sv
// WIDTH-bit carry-lookahead adder; c_msb is the carry into the top bit for overflow detection.
module cla_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             c_msb,
  output logic             co
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is built as its own sum-of-products over all lower g/p terms.
  always_comb begin
    w_c    = '0;
    w_c[0] = ci;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_c[i+1] = ci;
      for (int unsigned j = 0; j <= i; j++) begin
        w_c[i+1] = w_g[j] | (w_p[j] & w_c[i+1]);
      end
    end
  end

  assign s     = w_p ^ w_c[WIDTH-1:0];
  assign c_msb = w_c[WIDTH-1];
  assign co    = w_c[WIDTH];

endmodule

// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with start/done handshake.
// Define ALU_MUL_EN to compile in the multi-cycle shift-add multiplier (op 1000).
module alu_nbit_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  logic [WIDTH-1:0] w_cla_a;
  logic [WIDTH-1:0] w_cla_b;
  logic             w_cla_ci;
  logic [WIDTH-1:0] w_sum;
  logic             w_c_msb;
  logic             w_co;

  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_single;

  logic [WIDTH-1:0] r_result;
  logic             r_c;
  logic             r_n;
  logic             r_z;
  logic             r_v;
  logic             r_done;

  cla_n #(.WIDTH(WIDTH)) u_cla (
    .a     (w_cla_a),
    .b     (w_cla_b),
    .ci    (w_cla_ci),
    .s     (w_sum),
    .c_msb (w_c_msb),
    .co    (w_co)
  );

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_NOTA: w_res = ~a;
      OP_NOTB: w_res = ~b;
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_XNOR: w_res = ~(a ^ b);
      OP_ADD, OP_SUB: begin
        w_res = w_sum;
        w_c   = w_co;
        w_v   = w_c_msb ^ w_co;
      end
      default: w_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int unsigned CW = clog2(WIDTH + 1);

  alu_state_e         r_state;
  alu_state_e         w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_busy;
  logic               w_mul_load;
  logic               w_mul_step;
  logic               w_mul_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_single    = 1'b0;
    w_mul_load  = 1'b0;
    w_mul_step  = 1'b0;
    w_mul_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            w_mul_load  = 1'b1;
            w_state_nxt = S_MUL;
          end else begin
            w_single = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_mul_step = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_mul_last  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // While multiplying, the adder accumulates the multiplicand into the product's upper half.
  assign w_cla_a    = (r_state == S_MUL) ? r_prod[2*WIDTH-1:WIDTH] : a;
  assign w_cla_b    = (r_state == S_MUL) ? (r_prod[0] ? r_mcand : '0) : (op[0] ? ~b : b);
  assign w_cla_ci   = (r_state == S_MUL) ? 1'b0 : op[0];
  assign w_prod_nxt = {w_co, w_sum, r_prod[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_busy  <= 1'b0;
    end else begin
      if (w_mul_load) begin
        r_mcand <= a;
        r_prod  <= {{WIDTH{1'b0}}, b};
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end
      if (w_mul_step) begin
        r_prod <= w_prod_nxt;
        r_cnt  <= r_cnt + CW'(1);
      end
      if (w_mul_last) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign result_hi = r_result_hi;
`else
  assign w_single  = start;
  assign w_cla_a   = a;
  assign w_cla_b   = op[0] ? ~b : b;
  assign w_cla_ci  = op[0];
  assign busy      = 1'b0;
  assign result_hi = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
      r_done   <= 1'b0;
`ifdef ALU_MUL_EN
      r_result_hi <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_single) begin
        r_result <= w_res;
        r_c      <= w_c;
        r_n      <= w_res[WIDTH-1];
        r_z      <= (w_res == '0);
        r_v      <= w_v;
        r_done   <= 1'b1;
`ifdef ALU_MUL_EN
        r_result_hi <= '0;
`endif
      end
`ifdef ALU_MUL_EN
      if (w_mul_last) begin
        r_result    <= w_prod_nxt[WIDTH-1:0];
        r_result_hi <= w_prod_nxt[2*WIDTH-1:WIDTH];
        r_c         <= 1'b0;
        r_n         <= w_prod_nxt[2*WIDTH-1];
        r_z         <= (w_prod_nxt == '0);
        r_v         <= (w_prod_nxt[2*WIDTH-1:WIDTH] != '0);
        r_done      <= 1'b1;
      end
`endif
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign c      = r_c;
  assign n      = r_n;
  assign z      = r_z;
  assign v      = r_v;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed self-checking bench for alu_nbit_seq at WIDTH=8; MUL steps compile only with ALU_MUL_EN.
module tb_alu_nbit_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         c;
  logic         n;
  logic         z;
  logic         v;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .c         (c),
    .n         (n),
    .z         (z),
    .v         (v)
  );

  always #5 clk = ~clk;

  // Observation vector: {done, busy, result_hi, result, c, n, z, v}
  function automatic logic [2*W+5:0] obs();
    return {done, busy, result_hi, result, c, n, z, v};
  endfunction

  function automatic logic [2*W+5:0] ex(input logic d, input logic bz,
                                        input logic [W-1:0] hi, input logic [W-1:0] lo,
                                        input logic fc, input logic fn,
                                        input logic fz, input logic fv);
    return {d, bz, hi, lo, fc, fn, fz, fv};
  endfunction

  task automatic chk(input string tag, input logic [2*W+5:0] o, input logic [2*W+5:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] o, input logic [1:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s done/busy observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Drive inputs away from the edge, advance one rising edge, settle 2ns after it.
  task automatic cyc(input logic s, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = s;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #20;
    chk("reset", obs(), ex(0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    #2;

    cyc(1, 4'b0110, 8'h7F, 8'h01);
    chk("add_7f_01", obs(), ex(1, 0, 8'h00, 8'h80, 0, 1, 0, 1));
    cyc(0, 4'b0110, 8'h33, 8'h44);
    chk("idle_hold1", obs(), ex(0, 0, 8'h00, 8'h80, 0, 1, 0, 1));

    cyc(1, 4'b0111, 8'h05, 8'h05);
    chk("sub_eq", obs(), ex(1, 0, 8'h00, 8'h00, 1, 0, 1, 0));
    cyc(1, 4'b0111, 8'h00, 8'h01);
    chk("sub_borrow", obs(), ex(1, 0, 8'h00, 8'hFF, 0, 1, 0, 0));

    cyc(1, 4'b0101, 8'hF0, 8'hFF);
    chk("xnor_b2b", obs(), ex(1, 0, 8'h00, 8'hF0, 0, 1, 0, 0));
    cyc(1, 4'b0010, 8'h0F, 8'hF0);
    chk("and_b2b", obs(), ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 0));
    cyc(0, 4'b0000, 8'h00, 8'h00);
    chk("idle_hold2", obs(), ex(0, 0, 8'h00, 8'h00, 0, 0, 1, 0));

    cyc(1, 4'b0011, 8'h0A, 8'h50);
    chk("or", obs(), ex(1, 0, 8'h00, 8'h5A, 0, 0, 0, 0));
    cyc(1, 4'b0100, 8'h3C, 8'hFF);
    chk("xor", obs(), ex(1, 0, 8'h00, 8'hC3, 0, 1, 0, 0));
    cyc(1, 4'b0000, 8'h00, 8'h12);
    chk("nota", obs(), ex(1, 0, 8'h00, 8'hFF, 0, 1, 0, 0));
    cyc(1, 4'b0001, 8'h55, 8'h0F);
    chk("notb", obs(), ex(1, 0, 8'h00, 8'hF0, 0, 1, 0, 0));
    cyc(1, 4'b0110, 8'hFF, 8'h01);
    chk("add_wrap", obs(), ex(1, 0, 8'h00, 8'h00, 1, 0, 1, 0));
    cyc(1, 4'b0110, 8'h80, 8'h80);
    chk("add_negovf", obs(), ex(1, 0, 8'h00, 8'h00, 1, 0, 1, 1));
    cyc(1, 4'b0111, 8'h80, 8'h01);
    chk("sub_ovf", obs(), ex(1, 0, 8'h00, 8'h7F, 1, 0, 0, 1));
    cyc(1, 4'b1111, 8'hFF, 8'hFF);
    chk("illegal", obs(), ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 0));

`ifdef ALU_MUL_EN
    cyc(1, 4'b1000, 8'hFF, 8'hFF);
    chk("mul_start", obs(), ex(0, 1, 8'h00, 8'h00, 0, 0, 1, 0));
    for (int j = 1; j <= 8; j++) begin
      if (j == 3) cyc(1, 4'b0110, 8'h01, 8'h01);
      else        cyc(0, 4'b0000, 8'h00, 8'h00);
      if (j < 8) chk2("mul_busy", {done, busy}, 2'b01);
    end
    chk("mul_ffxff", obs(), ex(1, 0, 8'hFE, 8'h01, 0, 1, 0, 1));
    cyc(0, 4'b0000, 8'h00, 8'h00);
    chk("mul_after", obs(), ex(0, 0, 8'hFE, 8'h01, 0, 1, 0, 1));

    cyc(1, 4'b1000, 8'h10, 8'h10);
    for (int j = 1; j <= 8; j++) cyc(0, 4'b0000, 8'h00, 8'h00);
    chk("mul_10x10", obs(), ex(1, 0, 8'h01, 8'h00, 0, 0, 0, 1));

    cyc(1, 4'b1000, 8'h12, 8'h34);
    cyc(0, 4'b0000, 8'h00, 8'h00);
    cyc(0, 4'b0000, 8'h00, 8'h00);
    cyc(0, 4'b0000, 8'h00, 8'h00);
    #1 reset_n = 1'b0;
    #1;
    chk("mul_abort", obs(), ex(0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    cyc(0, 4'b0000, 8'h00, 8'h00);
    chk("abort_hold", obs(), ex(0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    cyc(1, 4'b0110, 8'h01, 8'h01);
    chk("add_after_rst", obs(), ex(1, 0, 8'h00, 8'h02, 0, 0, 0, 0));
`else
    cyc(1, 4'b0110, 8'h01, 8'h01);
    chk("add_1_1", obs(), ex(1, 0, 8'h00, 8'h02, 0, 0, 0, 0));
    cyc(1, 4'b1000, 8'h03, 8'h04);
    chk("mul_disabled", obs(), ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 0));
    cyc(0, 4'b0000, 8'h00, 8'h00);
    chk("mul_dis_hold", obs(), ex(0, 0, 8'h00, 8'h00, 0, 0, 1, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_nbit_seq.md
# alu_nbit_seq

Registered, parametrised-width ALU with a start/done handshake. It is the successor to the 4-bit combinational ALU. It keeps the same eight logic and arithmetic operations and the C/N/Z/V flag semantics, generalised to WIDTH bits. Operands, result and flags are captured in registers, and an optional multi-cycle shift-add multiplier can be compiled in. The block sits between the register file/operand latches and the status register of the datapath.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥ 2)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on rising clk when busy=0
- op  input  4  operation code (see Operation)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse: result/flags updated
- result  output  WIDTH  result (low half for MUL)
- result_hi  output  WIDTH  high half of product; 0 for all other ops
- c, n, z, v  output  1 each  carry, negative, zero, overflow flags

## Operation
Op codes:
- 0000 NOT A
- 0001 NOT B
- 0010 AND
- 0011 OR
- 0100 XOR
- 0101 XNOR
- 0110 ADD (a+b, ci=0)
- 0111 SUB (a+~b, ci=1)
- 1000 MUL (unsigned), only with ALU_MUL_EN
- Any other code is illegal: result=0, flags c=n=v=0, z=1, completes in one cycle.

Flags:
- n = result[WIDTH-1]
- z = (result==0)
- ADD/SUB: c = carry out of bit WIDTH-1; v = carry into MSB XOR carry out of MSB.
- SUB: c=1 means no borrow.
- Logic ops: c=0, v=0.
- MUL: n = result_hi[WIDTH-1]; z over the full 2·WIDTH product; c=0; v = (result_hi != 0).

FSM states (held in alu_pkg):
- IDLE: start=1 with a single-cycle op → compute, register result/flags, done=1, stay IDLE. start=1 with MUL → load multiplicand/multiplier, clear accumulator, count=0, busy=1, go MUL.
- MUL: one shift-add step per cycle. start is ignored. On step WIDTH: write {result_hi, result}, flags, done=1, busy=0, return to IDLE.

Register rules:
- result, result_hi and flags hold their value until the next accepted operation.
- a, b and op need only be valid at the accepting edge; they are latched internally.

## Timing
- Reset: all outputs 0, state IDLE, count 0. Reset asserted mid-MUL aborts the multiply immediately with no done pulse.
- Single-cycle ops: start accepted at edge k; result, flags and done are valid after edge k. Latency is 1 and throughput is 1 op/cycle (back-to-back start allowed).
- MUL: start at edge k; busy=1 after edge k; done=1 and busy=0 after edge k+WIDTH. Latency is WIDTH cycles.
- A new start is accepted in the same cycle that done is high.
- done is never high two cycles in a row except for back-to-back single-cycle ops.
- start=0: outputs and flags are unchanged and done=0.

## Configuration
- ALU_MUL_EN defined: op 1000 runs the multi-cycle multiply, and the MUL state and counter are present.
- ALU_MUL_EN undefined: op 1000 is illegal (result=0, z=1, one cycle), busy is tied to 0, result_hi is tied to 0, and no counter or MUL state is synthesised.

## Structure
- Package alu_pkg holds:
  - the op-code localparams (OP_NOTA … OP_SUB, OP_MUL)
  - the state encoding (S_IDLE, S_MUL)
  - the counter width function clog2(WIDTH+1)
- Sub-module cla_n is a parametrised WIDTH-bit carry-lookahead adder with ports a, b, ci, s, c_msb, co.
  - One instance handles ADD/SUB: b is muxed with ~b and ci with op[0].
  - The MUL accumulate reuses the same instance.

## Test plan
WIDTH=8, ALU_MUL_EN defined unless stated.
1. Reset → all outputs 0, busy=0. Then ADD a=0x7F, b=0x01 → after next edge result=0x80, n=1, v=1, c=0, z=0, done pulses one cycle.
2. SUB a=0x05, b=0x05 → result=0x00, z=1, c=1, v=0. Then SUB a=0x00, b=0x01 → 0xFF, c=0, n=1.
3. Back-to-back XNOR (0xF0, 0xFF) then AND (0x0F, 0xF0) on consecutive cycles → 0xF0 (n=1), then 0x00 (z=1), done high two cycles.
4. MUL 0xFF×0xFF → done exactly 8 cycles after start; {result_hi, result}=0xFE01, v=1, n=1. A start/ADD issued at cycle 3 is ignored.
5. Start MUL 0x12×0x34, assert reset_n=0 at cycle 4 → outputs 0 and busy=0 immediately. After release, ADD 0x01+0x01 → 0x02.
6. ALU_MUL_EN undefined: op=1000 → result=0, z=1, done after one cycle, busy never rises.
